// File: rtl/onchip_mem_cmd_master_if.sv
// Command-side and RAM-side signal bundle for onchip_mem_cmd_master.
// The master modport is the command engine's view; slave is the environment's view
// (control register block plus the RAM s2 port).
interface onchip_mem_cmd_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    // command side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_W-1:0]     cmd_src;
    logic [ADDR_W-1:0]     cmd_dst;
    logic [ADDR_W:0]       cmd_len;
    logic [DATA_W-1:0]     cmd_data;
    logic                  done;
    logic                  error;
    logic [DATA_W-1:0]     result;

    // RAM side (Avalon-MM, 1-cycle read latency)
    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W/8-1:0]   mem_byteenable;
    logic                  mem_chipselect;
    logic                  mem_write;
    logic [DATA_W-1:0]     mem_writedata;
    logic                  mem_clken;
    logic [DATA_W-1:0]     mem_readdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data, mem_readdata,
        output cmd_ready, done, error, result,
               mem_address, mem_byteenable, mem_chipselect, mem_write,
               mem_writedata, mem_clken
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data, mem_readdata,
        input  cmd_ready, done, error, result,
               mem_address, mem_byteenable, mem_chipselect, mem_write,
               mem_writedata, mem_clken
    );
endinterface

// File: rtl/onchip_mem_cmd_master.sv
// Bulk memory command engine for the 4096x32 on-chip RAM: block fill with an
// incrementing pattern, block checksum, and ascending block copy.
module onchip_mem_cmd_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    onchip_mem_cmd_master_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SUM_RD,
        ST_SUM_DRAIN,
        ST_CP_RD,
        ST_CP_WR,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] A_ONE   = 1;
    localparam logic [DATA_W-1:0] D_ONE   = 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                error_q, error_d;
    logic                rd_pend_q, rd_pend_d;

    logic accept;
    logic cmd_bad;
    logic cmd_empty;

    assign accept    = (state_q == ST_IDLE) && bus.cmd_valid && !reset;
    assign cmd_empty = (bus.cmd_len == '0);
    assign cmd_bad   = (bus.cmd_op == 2'd3) || (bus.cmd_len > MAX_LEN);

    // State and work registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            pat_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            error_q   <= error_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Next-state: route on accept, leave each access phase after its last word
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_empty || cmd_bad) begin
                        state_d = ST_DONE;
                    end else begin
                        case (bus.cmd_op)
                            2'd0:    state_d = ST_FILL;
                            2'd1:    state_d = ST_SUM_RD;
                            default: state_d = ST_CP_RD;
                        endcase
                    end
                end
            end
            ST_FILL:      if (cnt_q == CNT_ONE) state_d = ST_DONE;
            ST_SUM_RD:    if (cnt_q == CNT_ONE) state_d = ST_SUM_DRAIN;
            ST_SUM_DRAIN: state_d = ST_DONE;
            ST_CP_RD:     state_d = ST_CP_WR;
            ST_CP_WR:     state_d = (cnt_q == CNT_ONE) ? ST_DONE : ST_CP_RD;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath: address/pattern stepping, remaining count and checksum accumulation.
    // Read data arrives one cycle after issue, so a pending flag gates accumulation.
    always_comb begin
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        acc_d     = acc_q;
        result_d  = result_q;
        error_d   = error_q;
        rd_pend_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    src_d    = bus.cmd_src;
                    dst_d    = bus.cmd_dst;
                    cnt_d    = bus.cmd_len;
                    pat_d    = bus.cmd_data;
                    acc_d    = '0;
                    result_d = '0;
                    error_d  = !cmd_empty && cmd_bad;
                end
            end
            ST_FILL: begin
                dst_d = dst_q + A_ONE;
                pat_d = pat_q + D_ONE;
                cnt_d = cnt_q - CNT_ONE;
            end
            ST_SUM_RD: begin
                src_d     = src_q + A_ONE;
                cnt_d     = cnt_q - CNT_ONE;
                rd_pend_d = 1'b1;
                if (rd_pend_q) acc_d = acc_q + bus.mem_readdata;
            end
            ST_SUM_DRAIN: begin
                acc_d    = acc_q + bus.mem_readdata;
                result_d = acc_q + bus.mem_readdata;
            end
            ST_CP_RD: begin
                src_d = src_q + A_ONE;
            end
            ST_CP_WR: begin
                dst_d = dst_q + A_ONE;
                cnt_d = cnt_q - CNT_ONE;
            end
            default: ;
        endcase
    end

    // Outputs: bus strobes decoded from state, all forced quiet while reset is high
    always_comb begin
        bus.cmd_ready      = (state_q == ST_IDLE) && !reset;
        bus.done           = (state_q == ST_DONE) && !reset;
        bus.error          = error_q;
        bus.result         = result_q;
        bus.mem_byteenable = '1;
        bus.mem_clken      = 1'b1;
        bus.mem_chipselect = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_writedata  = '0;
        if (!reset) begin
            case (state_q)
                ST_FILL: begin
                    bus.mem_chipselect = 1'b1;
                    bus.mem_write      = 1'b1;
                    bus.mem_address    = dst_q;
                    bus.mem_writedata  = pat_q;
                end
                ST_SUM_RD, ST_CP_RD: begin
                    bus.mem_chipselect = 1'b1;
                    bus.mem_address    = src_q;
                end
                ST_CP_WR: begin
                    bus.mem_chipselect = 1'b1;
                    bus.mem_write      = 1'b1;
                    bus.mem_address    = dst_q;
                    bus.mem_writedata  = bus.mem_readdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_cmd_master.sv
// Randomised bench for onchip_mem_cmd_master: a behavioural RAM on the s2 side and a
// command-level reference model that predicts the per-cycle bus trace and results.
module tb_onchip_mem_cmd_master;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ram_load = 1'b1;

    always #5 clk = ~clk;

    onchip_mem_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    onchip_mem_cmd_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // RAM: registered address, unregistered output (1-cycle read latency)
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_addr_q = '0;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
        end else if (bus.mem_chipselect && bus.mem_clken) begin
            ram_addr_q <= bus.mem_address;
            if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
        end
    end

    assign bus.mem_readdata = ram[ram_addr_q];

    // Reference memory image, updated command by command
    logic [DW-1:0] ref_mem [DEPTH];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic cs, input logic we,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {18'b0, cs, we, a, d};
    endfunction

    function automatic logic [63:0] bus_vec();
        return mk(bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_writedata);
    endfunction

    task automatic noise();
        bus.cmd_valid = ($urandom_range(0, 2) == 0);
        bus.cmd_op    = 2'($urandom);
        bus.cmd_src   = AW'($urandom);
        bus.cmd_dst   = AW'($urandom);
        bus.cmd_len   = 13'($urandom_range(1, 8));
        bus.cmd_data  = $urandom;
    endtask

    // Issue one command from an idle cycle, predict its bus trace and check every cycle
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input logic [AW:0] len,
                           input logic [DW-1:0] seed, output logic [DW-1:0] res_out);
        logic [63:0]   exp_q[$];
        int            done_cyc;
        logic          exp_err;
        logic [DW-1:0] exp_res;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] v;

        exp_err = 1'b0;
        exp_res = '0;
        res_out = '0;
        done_cyc = 1;
        if (len == 0) begin
            done_cyc = 1;
        end else if (op == 2'd3 || int'(len) > DEPTH) begin
            exp_err  = 1'b1;
            done_cyc = 1;
        end else if (op == 2'd0) begin
            for (int k = 0; k < int'(len); k++) begin
                wa = dst + AW'(k);
                v  = seed + DW'(k);
                exp_q.push_back(mk(1'b1, 1'b1, wa, v));
                ref_mem[wa] = v;
            end
            done_cyc = int'(len) + 1;
        end else if (op == 2'd1) begin
            for (int k = 0; k < int'(len); k++) begin
                ra = src + AW'(k);
                exp_q.push_back(mk(1'b1, 1'b0, ra, '0));
                exp_res = exp_res + ref_mem[ra];
            end
            exp_q.push_back(mk(1'b0, 1'b0, '0, '0));
            done_cyc = int'(len) + 2;
        end else begin
            for (int k = 0; k < int'(len); k++) begin
                ra = src + AW'(k);
                wa = dst + AW'(k);
                v  = ref_mem[ra];
                exp_q.push_back(mk(1'b1, 1'b0, ra, '0));
                exp_q.push_back(mk(1'b1, 1'b1, wa, v));
                ref_mem[wa] = v;
            end
            done_cyc = 2 * int'(len) + 1;
        end

        chk("ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
        bus.cmd_len   = len;
        bus.cmd_data  = seed;
        @(posedge clk);
        #1;
        for (int c = 1; c <= done_cyc; c++) begin
            if (c < done_cyc) begin
                chk("bus", bus_vec(), exp_q[c-1]);
                chk("done_early", 64'(bus.done), 64'd0);
                chk("ready_busy", 64'(bus.cmd_ready), 64'd0);
            end else begin
                chk("done", 64'(bus.done), 64'd1);
                chk("done_bus", bus_vec(), 64'd0);
                chk("error", 64'(bus.error), 64'(exp_err));
                chk("result", 64'(bus.result), 64'(exp_res));
                chk("ready_done", 64'(bus.cmd_ready), 64'd0);
                res_out = bus.result;
            end
            noise();
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        chk("ready_after", 64'(bus.cmd_ready), 64'd1);
        chk("done_after", 64'(bus.done), 64'd0);
        chk("result_hold", 64'(bus.result), 64'(exp_res));
        chk("error_hold", 64'(bus.error), 64'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] r;
        logic [1:0]    op;
        logic [AW:0]   len;
        int            sel;
        int            mism;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge clk);
        #1;
        ram_load = 1'b0;
        chk("rst_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_bus", bus_vec(), 64'd0);
        chk("rst_be", 64'(bus.mem_byteenable), 64'hF);
        chk("rst_clken", 64'(bus.mem_clken), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_ready", 64'(bus.cmd_ready), 64'd1);

        // directed cases
        run_cmd(2'd0, 12'h000, 12'h010, 13'd4, 32'h0000_00A0, r);
        run_cmd(2'd1, 12'h010, 12'h000, 13'd4, 32'h0, r);
        chk("sum_a0_a3", 64'(r), 64'h286);
        run_cmd(2'd2, 12'h010, 12'hFFE, 13'd4, 32'h0, r);
        chk("copy_wrap_000", 64'(ram[0]), 64'hA2);
        chk("copy_wrap_fff", 64'(ram[12'hFFF]), 64'hA1);
        run_cmd(2'd1, 12'h123, 12'h000, 13'd0, 32'h0, r);
        run_cmd(2'd3, 12'h000, 12'h000, 13'd3, 32'h0, r);
        run_cmd(2'd0, 12'h000, 12'h000, 13'h1001, 32'h0, r);

        // reset in cycle 2 of an 8-word fill: only word 0 lands
        chk("ready_pre_rst", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_dst   = 12'h100;
        bus.cmd_len   = 13'd8;
        bus.cmd_data  = 32'h55;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("rst_w0", bus_vec(), mk(1'b1, 1'b1, 12'h100, 32'h55));
        ref_mem[12'h100] = 32'h55;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_gate_bus", bus_vec(), 64'd0);
        chk("rst_gate_done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.cmd_ready), 64'd1);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        chk("mid_rst_bus", bus_vec(), 64'd0);
        chk("mid_rst_result", 64'(bus.result), 64'd0);
        run_cmd(2'd1, 12'h010, 12'h000, 13'd4, 32'h0, r);
        chk("sum_after_rst", 64'(r), 64'h286);

        // modular checksum wrap
        run_cmd(2'd0, 12'h000, 12'h200, 13'd1, 32'hFFFF_FFFF, r);
        run_cmd(2'd0, 12'h000, 12'h201, 13'd1, 32'h0000_0002, r);
        run_cmd(2'd1, 12'h200, 12'h000, 13'd2, 32'h0, r);
        chk("sum_wrap", 64'(r), 64'h1);

        // full-depth boundary
        run_cmd(2'd0, 12'h000, 12'h007, 13'h1000, 32'hFFFF_FF00, r);
        run_cmd(2'd1, 12'h800, 12'h000, 13'h1000, 32'h0, r);

        // randomised commands, including overlapping copies
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) op = 2'd3;
            else op = 2'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 9));
            if (sel == 0) len = '0;
            else if (sel == 1) len = 13'($urandom_range(4097, 8191));
            else len = 13'($urandom_range(1, 32));
            if (op == 2'd2 && $urandom_range(0, 1) == 1) begin
                bus.cmd_src = AW'($urandom);
                run_cmd(op, bus.cmd_src, bus.cmd_src + AW'($urandom_range(1, 3)), len, $urandom, r);
            end else begin
                run_cmd(op, AW'($urandom), AW'($urandom), len, $urandom, r);
            end
        end

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("ram_image", 64'(mism), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
